// File: rtl/cv32e40p_apu_core_pkg.sv
// Shared APU parameters for the cv32e40p core-side APU interface
// and the multi-requester APU arbiter.
package cv32e40p_apu_core_pkg;

   localparam int APU_NARGS_CPU    = 3;
   localparam int APU_WOP_CPU      = 6;
   localparam int APU_NDSFLAGS_CPU = 15;
   localparam int APU_NUSFLAGS_CPU = 5;

   localparam int APU_ARB_NREQ            = 2;
   localparam int APU_ARB_MAX_OUTSTANDING = 4;

endpackage

// File: rtl/cv32e40p_apu_arb_fifo.sv
// In-order tag FIFO recording which requester owns each outstanding
// APU operation. Pushes when full and pops when empty are ignored.
module cv32e40p_apu_arb_fifo #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push_i,
   input  logic                      pop_i,
   input  logic [WIDTH-1:0]          data_i,
   output logic [WIDTH-1:0]          data_o,
   output logic                      full_o,
   output logic                      empty_o,
   output logic [$clog2(DEPTH):0]    count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q;
   logic [AW-1:0]    rptr_q;
   logic [AW:0]      cnt_q;
   logic             do_push;
   logic             do_pop;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign data_o  = mem_q[rptr_q];
   assign count_o = cnt_q;

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= data_i;
   end

   // Power-of-2 depth lets the pointers wrap by plain overflow
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + 1'b1;
         if (do_pop)  rptr_q <= rptr_q + 1'b1;
         if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
         else if (!do_push && do_pop) cnt_q <= cnt_q - 1'b1;
      end
   end

endmodule

// File: rtl/cv32e40p_apu_arbiter.sv
// Round-robin arbiter sharing one APU port among NREQ dispatchers;
// responses are routed back in order through a tag FIFO.
module cv32e40p_apu_arbiter
   import cv32e40p_apu_core_pkg::*;
#(
   parameter int NREQ             = APU_ARB_NREQ,
   parameter int MAX_OUTSTANDING  = APU_ARB_MAX_OUTSTANDING,
   parameter int APU_NARGS_CPU    = cv32e40p_apu_core_pkg::APU_NARGS_CPU,
   parameter int APU_WOP_CPU      = cv32e40p_apu_core_pkg::APU_WOP_CPU,
   parameter int APU_NDSFLAGS_CPU = cv32e40p_apu_core_pkg::APU_NDSFLAGS_CPU,
   parameter int APU_NUSFLAGS_CPU = cv32e40p_apu_core_pkg::APU_NUSFLAGS_CPU
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic [NREQ-1:0]                             req_i,
   input  logic [NREQ-1:0][APU_NARGS_CPU-1:0][31:0]    operands_i,
   input  logic [NREQ-1:0][APU_WOP_CPU-1:0]            op_i,
   input  logic [NREQ-1:0][APU_NDSFLAGS_CPU-1:0]       flags_i,
   output logic [NREQ-1:0]                             gnt_o,
   output logic [NREQ-1:0]                             rvalid_o,
   output logic [31:0]                                 result_o,
   output logic [APU_NUSFLAGS_CPU-1:0]                 rflags_o,
   output logic                                        apu_req_o,
   input  logic                                        apu_gnt_i,
   output logic [APU_NARGS_CPU-1:0][31:0]              apu_operands_o,
   output logic [APU_WOP_CPU-1:0]                      apu_op_o,
   output logic [APU_NDSFLAGS_CPU-1:0]                 apu_flags_o,
   input  logic                                        apu_rvalid_i,
   input  logic [31:0]                                 apu_result_i,
   input  logic [APU_NUSFLAGS_CPU-1:0]                 apu_flags_i,
   output logic                                        busy_o,
   output logic [$clog2(MAX_OUTSTANDING):0]            outstanding_o,
   output logic                                        err_o
);

   localparam int TW = $clog2(NREQ);

   logic [TW-1:0] rr_q, rr_d;
   logic [TW-1:0] win;
   logic [TW-1:0] head;
   logic          found;
   int            idx;
   logic          full, empty;
   logic          accept, pop;
   logic          err_q, err_d;

   // Scan from rr_q upward with wrap; first requester found wins
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = 0;
      for (int i = 0; i < NREQ; i++) begin
         idx = (int'(rr_q) + i) % NREQ;
         if (!found && req_i[idx]) begin
            found = 1'b1;
            win   = TW'(idx);
         end
      end
   end

   assign apu_req_o = (|req_i) & ~full & ~rst;
   assign accept    = apu_req_o & apu_gnt_i;
   assign pop       = apu_rvalid_i & ~empty;

   always_comb begin
      apu_operands_o = '0;
      apu_op_o       = '0;
      apu_flags_o    = '0;
      if (found) begin
         apu_operands_o = operands_i[win];
         apu_op_o       = op_i[win];
         apu_flags_o    = flags_i[win];
      end
   end

   always_comb begin
      gnt_o    = '0;
      rvalid_o = '0;
      if (accept) gnt_o[win]  = 1'b1;
      if (pop)    rvalid_o[head] = 1'b1;
   end

   assign result_o = apu_result_i;
   assign rflags_o = apu_flags_i;

   always_comb begin
      rr_d = rr_q;
      if (accept) rr_d = (win == TW'(NREQ-1)) ? '0 : win + 1'b1;
   end

   assign err_d = err_q | (apu_rvalid_i & empty);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_q  <= '0;
         err_q <= 1'b0;
      end else begin
         rr_q  <= rr_d;
         err_q <= err_d;
      end
   end

   assign err_o  = err_q;
   assign busy_o = ~empty;

   cv32e40p_apu_arb_fifo #(
      .WIDTH (TW),
      .DEPTH (MAX_OUTSTANDING)
   ) u_tag_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (accept),
      .pop_i   (pop),
      .data_i  (win),
      .data_o  (head),
      .full_o  (full),
      .empty_o (empty),
      .count_o (outstanding_o)
   );

endmodule

// File: tb/tb_cv32e40p_apu_arbiter.sv
// Directed bench for the round-robin APU arbiter with two requesters.
module tb_cv32e40p_apu_arbiter;

   logic               clk = 1'b0;
   logic               rst;
   logic [1:0]         req_i;
   logic [1:0][2:0][31:0] operands_i;
   logic [1:0][5:0]    op_i;
   logic [1:0][14:0]   flags_i;
   logic [1:0]         gnt_o;
   logic [1:0]         rvalid_o;
   logic [31:0]        result_o;
   logic [4:0]         rflags_o;
   logic               apu_req_o;
   logic               apu_gnt_i;
   logic [2:0][31:0]   apu_operands_o;
   logic [5:0]         apu_op_o;
   logic [14:0]        apu_flags_o;
   logic               apu_rvalid_i;
   logic [31:0]        apu_result_i;
   logic [4:0]         apu_flags_i;
   logic               busy_o;
   logic [2:0]         outstanding_o;
   logic               err_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cv32e40p_apu_arbiter dut (
      .clk            (clk),
      .rst            (rst),
      .req_i          (req_i),
      .operands_i     (operands_i),
      .op_i           (op_i),
      .flags_i        (flags_i),
      .gnt_o          (gnt_o),
      .rvalid_o       (rvalid_o),
      .result_o       (result_o),
      .rflags_o       (rflags_o),
      .apu_req_o      (apu_req_o),
      .apu_gnt_i      (apu_gnt_i),
      .apu_operands_o (apu_operands_o),
      .apu_op_o       (apu_op_o),
      .apu_flags_o    (apu_flags_o),
      .apu_rvalid_i   (apu_rvalid_i),
      .apu_result_i   (apu_result_i),
      .apu_flags_i    (apu_flags_i),
      .busy_o         (busy_o),
      .outstanding_o  (outstanding_o),
      .err_o          (err_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] r, input logic g,
                        input logic rv, input logic [31:0] res);
      req_i        = r;
      apu_gnt_i    = g;
      apu_rvalid_i = rv;
      apu_result_i = res;
      apu_flags_i  = res[4:0];
      #1;
   endtask

   initial begin
      rst = 1'b1;
      operands_i[0] = {32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
      operands_i[1] = {32'hB000_0002, 32'hB000_0001, 32'hB000_0000};
      op_i[0]    = 6'h11;
      op_i[1]    = 6'h22;
      flags_i[0] = 15'h0AAA;
      flags_i[1] = 15'h0555;
      drive(2'b00, 1'b0, 1'b0, 32'h0);
      #1;
      chk("rst_gnt", 32'(gnt_o), 32'h0);
      chk("rst_rvalid", 32'(rvalid_o), 32'h0);
      chk("rst_req", 32'(apu_req_o), 32'h0);
      chk("rst_busy", 32'(busy_o), 32'h0);
      chk("rst_cnt", 32'(outstanding_o), 32'h0);
      chk("rst_err", 32'(err_o), 32'h0);
      chk("rst_payload", apu_operands_o[0], 32'h0);
      cyc();
      cyc();
      rst = 1'b0;

      // round robin: 01,10,01,10
      for (int k = 0; k < 4; k++) begin
         drive(2'b11, 1'b1, 1'b0, 32'h0);
         chk("rr_gnt", 32'(gnt_o), (k % 2 == 0) ? 32'h1 : 32'h2);
         chk("rr_op", 32'(apu_op_o), (k % 2 == 0) ? 32'h11 : 32'h22);
         chk("rr_opnd2", apu_operands_o[2],
             (k % 2 == 0) ? 32'hA000_0002 : 32'hB000_0002);
         cyc();
      end
      chk("rr_full_cnt", 32'(outstanding_o), 32'd4);
      chk("rr_full_req", 32'(apu_req_o), 32'h0);
      chk("rr_busy", 32'(busy_o), 32'h1);
      for (int k = 0; k < 4; k++) begin
         drive(2'b00, 1'b0, 1'b1, 32'hC0DE_0010 + 32'(k));
         chk("rr_rvalid", 32'(rvalid_o), (k % 2 == 0) ? 32'h1 : 32'h2);
         chk("rr_result", result_o, 32'hC0DE_0010 + 32'(k));
         chk("rr_rflags", 32'(rflags_o), 32'(5'h10 + 5'(k)));
         cyc();
      end
      drive(2'b00, 1'b0, 1'b0, 32'h0);
      chk("rr_drained", 32'(outstanding_o), 32'h0);
      chk("rr_nopayload", 32'(apu_op_o), 32'h0);

      // backpressure
      for (int k = 0; k < 3; k++) begin
         drive(2'b10, 1'b0, 1'b0, 32'h0);
         chk("bp_gnt", 32'(gnt_o), 32'h0);
         chk("bp_req", 32'(apu_req_o), 32'h1);
         chk("bp_op", 32'(apu_op_o), 32'h22);
         cyc();
      end
      drive(2'b11, 1'b0, 1'b0, 32'h0);
      chk("bp_rr_kept", 32'(apu_op_o), 32'h11);
      drive(2'b10, 1'b1, 1'b0, 32'h0);
      chk("bp_gnt1", 32'(gnt_o), 32'h2);
      cyc();
      drive(2'b00, 1'b0, 1'b0, 32'h0);
      chk("bp_cnt", 32'(outstanding_o), 32'h1);
      drive(2'b00, 1'b0, 1'b1, 32'h5);
      chk("bp_rvalid", 32'(rvalid_o), 32'h2);
      cyc();

      // full
      for (int k = 0; k < 4; k++) begin
         drive(2'b01, 1'b1, 1'b0, 32'h0);
         chk("full_gnt", 32'(gnt_o), 32'h1);
         cyc();
      end
      chk("full_cnt", 32'(outstanding_o), 32'd4);
      chk("full_req", 32'(apu_req_o), 32'h0);
      chk("full_nognt", 32'(gnt_o), 32'h0);
      drive(2'b01, 1'b1, 1'b1, 32'h77);
      chk("full_pop_req", 32'(apu_req_o), 32'h0);
      chk("full_pop_rv", 32'(rvalid_o), 32'h1);
      cyc();
      drive(2'b01, 1'b0, 1'b0, 32'h0);
      chk("full_cnt3", 32'(outstanding_o), 32'd3);
      chk("full_req_back", 32'(apu_req_o), 32'h1);
      for (int k = 0; k < 3; k++) begin
         drive(2'b00, 1'b0, 1'b1, 32'h0);
         chk("full_drain_rv", 32'(rvalid_o), 32'h1);
         cyc();
      end
      drive(2'b00, 1'b0, 1'b0, 32'h0);
      chk("full_drained", 32'(outstanding_o), 32'h0);

      // simultaneous push and pop at count 2
      drive(2'b10, 1'b1, 1'b0, 32'h0);
      chk("sim_gnt_a", 32'(gnt_o), 32'h2);
      cyc();
      drive(2'b01, 1'b1, 1'b0, 32'h0);
      chk("sim_gnt_b", 32'(gnt_o), 32'h1);
      cyc();
      drive(2'b01, 1'b1, 1'b1, 32'h99);
      chk("sim_cnt_before", 32'(outstanding_o), 32'd2);
      chk("sim_gnt", 32'(gnt_o), 32'h1);
      chk("sim_rvalid_oldest", 32'(rvalid_o), 32'h2);
      cyc();
      drive(2'b00, 1'b0, 1'b0, 32'h0);
      chk("sim_cnt_kept", 32'(outstanding_o), 32'd2);
      for (int k = 0; k < 2; k++) begin
         drive(2'b00, 1'b0, 1'b1, 32'h0);
         chk("sim_drain_rv", 32'(rvalid_o), 32'h1);
         cyc();
      end

      // response with empty FIFO
      drive(2'b00, 1'b0, 1'b1, 32'h0);
      chk("err_rvalid", 32'(rvalid_o), 32'h0);
      cyc();
      drive(2'b00, 1'b0, 1'b0, 32'h0);
      chk("err_cnt", 32'(outstanding_o), 32'h0);
      for (int k = 0; k < 10; k++) begin
         chk("err_hold", 32'(err_o), 32'h1);
         cyc();
      end
      rst = 1'b1;
      #1;
      chk("err_clear", 32'(err_o), 32'h0);
      cyc();
      rst = 1'b0;

      // reset mid-operation
      for (int k = 0; k < 3; k++) begin
         drive(2'b11, 1'b1, 1'b0, 32'h0);
         chk("mid_gnt", 32'(gnt_o), (k % 2 == 0) ? 32'h1 : 32'h2);
         cyc();
      end
      chk("mid_cnt3", 32'(outstanding_o), 32'd3);
      rst = 1'b1;
      #1;
      chk("mid_cnt0", 32'(outstanding_o), 32'h0);
      chk("mid_busy", 32'(busy_o), 32'h0);
      chk("mid_req", 32'(apu_req_o), 32'h0);
      chk("mid_gnt_rst", 32'(gnt_o), 32'h0);
      cyc();
      rst = 1'b0;
      #1;
      chk("mid_next_gnt", 32'(gnt_o), 32'h1);
      cyc();
      drive(2'b00, 1'b0, 1'b0, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cv32e40p_apu_arbiter.md
# cv32e40p_apu_arbiter

Shares one APU interconnect port (FPU or vector accelerator) between `NREQ` core-side APU dispatchers. Requests are arbitrated round-robin and forwarded with zero added latency. The index of each accepted request is recorded in an in-order tag FIFO, so each `apu_rvalid_i` response is routed back to the requester that issued it. The block sits between the per-core EX-stage APU request/response channels and the shared APU.

## Interface
- `NREQ`, default 2: number of requesters, at least 2.
- `MAX_OUTSTANDING`, default 4: tag FIFO depth, a power of 2 and at least 2.
- `APU_NARGS_CPU`, default 3: operands per request.
- `APU_WOP_CPU`, default 6: opcode width.
- `APU_NDSFLAGS_CPU`, default 15: downstream flag width.
- `APU_NUSFLAGS_CPU`, default 5: upstream flag width.

Ports:
- `clk`  in  1: the single clock.
- `rst`  in  1: asynchronous, active-high reset.
- `req_i`  in  NREQ: request per requester.
- `operands_i`  in  NREQ x APU_NARGS_CPU x 32: operands per requester.
- `op_i`  in  NREQ x APU_WOP_CPU: opcode per requester.
- `flags_i`  in  NREQ x APU_NDSFLAGS_CPU: downstream flags per requester.
- `gnt_o`  out  NREQ: one-hot grant.
- `rvalid_o`  out  NREQ: one-hot response valid.
- `result_o`  out  32: response result, broadcast to all requesters.
- `rflags_o`  out  APU_NUSFLAGS_CPU: response flags, broadcast.
- `apu_req_o`  out  1, `apu_gnt_i`  in  1: shared APU request handshake.
- `apu_operands_o`, `apu_op_o`, `apu_flags_o`  out: selected request payload.
- `apu_rvalid_i`  in  1, `apu_result_i`  in  32, `apu_flags_i`  in  APU_NUSFLAGS_CPU: shared APU response.
- `busy_o`  out  1: high while any operation is outstanding.
- `outstanding_o`  out  $clog2(MAX_OUTSTANDING)+1: count of outstanding operations.
- `err_o`  out  1: sticky protocol error.

## Operation
- **Winner selection:** the first index i, scanning from `rr_ptr` upward with wrap, that has `req_i[i]=1`.
- **Request forwarding:**
  - `apu_req_o` = |`req_i` & ~full & ~`rst`.
  - Payload mux selects the winner; with no request the payload is all zeros.
- **Grant:** `gnt_o[winner]` = `apu_req_o` & `apu_gnt_i`. All other grant bits are 0.
- **Accept** (`apu_req_o` & `apu_gnt_i`):
  - Push the winner index into the tag FIFO.
  - `rr_ptr` <= (winner+1) mod NREQ.
  - `rr_ptr` does not move without an accept.
- **Response** (`apu_rvalid_i`):
  - Pop the FIFO head h and drive `rvalid_o[h]=1`.
  - `result_o` = `apu_result_i` and `rflags_o` = `apu_flags_i`, combinationally in the same cycle.
- **Count:** push and pop in the same cycle leave the count unchanged; accept while full is impossible because `apu_req_o` is gated.
- **Response with empty FIFO:**
  - `rvalid_o` stays all-zero.
  - `err_o` is set and holds until reset.
  - The count is not decremented and does not underflow.
- **Requester obligation:** hold `req_i` and payload stable until granted. The arbiter does not latch the payload.
- **Response ordering:** the APU returns responses in acceptance order. The earliest response comes one cycle after its grant; a same-cycle `apu_rvalid_i` belongs to an older operation.

## Timing
- Request path, grant path and response routing are purely combinational: zero added cycles.
- The FIFO, `rr_ptr`, count and `err_o` update on the `clk` rising edge.
- **Reset values:**
  - `rr_ptr`=0, count=0, `err_o`=0, FIFO pointers=0.
  - `gnt_o`=0, `rvalid_o`=0, `apu_req_o`=0, `busy_o`=0.
- **Reset mid-operation:** all outstanding tags are discarded. Responses arriving after reset with an empty FIFO set `err_o`. The system resets the APU together with the arbiter.
- **Full** (count = MAX_OUTSTANDING): `apu_req_o`=0. If a pop happens that cycle, `apu_req_o` is re-enabled from the next cycle; there is no same-cycle bypass.
- **Wrap-around:** FIFO read and write pointers wrap modulo MAX_OUTSTANDING. `rr_ptr` wraps from NREQ-1 to 0.

## Structure
- `cv32e40p_apu_core_pkg` gains `APU_ARB_NREQ` (default 2) and `APU_ARB_MAX_OUTSTANDING` (default 4).
- Sub-module `cv32e40p_apu_arb_fifo`: a synchronous tag FIFO with width $clog2(NREQ), depth MAX_OUTSTANDING, `push_i`/`pop_i`/`data_i`/`data_o`/`full_o`/`empty_o`/`count_o`, and `clk`/`rst`.
- The top level holds the round-robin pointer, the winner scan, the muxes and the error flag.

## Test plan
- **Round-robin:** `req_i`=2'b11 with `apu_gnt_i`=1 for 4 cycles -> `gnt_o` sequence 01,10,01,10. Then 4 `apu_rvalid_i` pulses -> `rvalid_o` 01,10,01,10, with `result_o` equal to `apu_result_i` in each cycle.
- **Backpressure:** `req_i`[1]=1 and `apu_gnt_i`=0 for 3 cycles -> `gnt_o`=0, `apu_req_o`=1, `rr_ptr` unchanged. Then `apu_gnt_i`=1 -> `gnt_o`=10 and `outstanding_o`=1.
- **Full:** 4 accepts with no response -> `outstanding_o`=4 and `apu_req_o`=0 with `req_i`=1. Then one `apu_rvalid_i` -> count 3, and `apu_req_o`=1 the next cycle.
- **Simultaneous push and pop:** at count=2, accept plus response in the same cycle -> count stays 2, and `rvalid_o` targets the oldest tag.
- **Error:** `apu_rvalid_i`=1 with an empty FIFO -> `rvalid_o`=0 and `err_o`=1, held for 10 cycles. Asserting `rst` clears it.
- **Reset mid-operation:** 3 operations outstanding, assert `rst` for 1 cycle -> `outstanding_o`=0, `busy_o`=0, and the next grant goes to requester 0.
